mac_dot_sequencer: RTL and testbench

Issue-side controller for the MAC datapath. It accepts a dot-product job (mode, rounding mode, initial accumulator C, length K), then streams K operand pairs into the MAC one at a time. Each MAC result is fed back as the next IN3, so the K steps form a serial accumulation chain. The block drives the MAC's IN1/IN2/IN3/mode/rounding inputs, captures its 128-bit result and exception flags, and returns the final accumulator over a valid/ready result port.

---
 rtl/mac_seq_pkg.sv | 46 ++++
 rtl/mac_dot_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac_seq_pkg
//
// Shared definitions for the MAC dot-product issue sequencer:
//   - state_t      : sequencer FSM states
//   - MODE_*       : 3-bit MAC mode encodings driven on mac_mode_o
//   - FLG_*        : bit positions inside the 4-bit {NV,OF,UF,NX} flag vector
//   - is_fp_mode() : true for the modes whose MAC flags are meaningful
// -----------------------------------------------------------------------------
package mac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] MODE_FP16    = 3'b000;
    localparam logic [2:0] MODE_FP16MIX = 3'b001;
    localparam logic [2:0] MODE_FP32    = 3'b010;
    localparam logic [2:0] MODE_INT4    = 3'b011;
    localparam logic [2:0] MODE_ADJ16   = 3'b100;
    localparam logic [2:0] MODE_INT4MIX = 3'b101;
    localparam logic [2:0] MODE_INT8MIX = 3'b110;
    localparam logic [2:0] MODE_ILLEGAL = 3'b111;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam int ACC_W  = 128;
    localparam int OP_W   = 32;
    localparam int FLAG_W = 4;

    // Result flags reported for a job that carries the illegal mode.
    localparam logic [FLAG_W-1:0] FLAGS_ILLEGAL = 4'b0001 << FLG_NV;

    // Only the floating-point modes produce IEEE exception flags; in the
    // integer and adjacent-add modes the MAC flag pins are don't-care.
    function automatic logic is_fp_mode(input logic [2:0] mode);
        return (mode == MODE_FP16) || (mode == MODE_FP16MIX) || (mode == MODE_FP32);
    endfunction

endpackage

// File: rtl/mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer
//
// Issue-side controller for the MAC datapath. A job (mode, rounding mode,
// initial accumulator C, length K) is accepted, then K operand pairs are fed
// to the MAC one at a time. Each MAC result becomes the next IN3, so the steps
// form a serial accumulation chain. The final accumulator and the sticky
// exception flags are returned over a valid/ready result port.
//
// Parameters
//   MAC_LAT : cycles from a change on mac_*_o until mac_out_i reflects it
//   KW      : width of the job length field
//   PARM_RM : width of the rounding mode
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   job_valid_i / job_ready_o  job handshake
//   job_mode_i, job_rm_i       MAC mode and rounding mode for the job
//   job_len_i, job_c_i         number of operand pairs K, initial accumulator
//   op_valid_i / op_ready_o    operand handshake
//   op_a_i, op_b_i             operand pair
//   mac_in1_o .. mac_in3_o     MAC operand inputs (IN3 is the accumulator)
//   mac_mode_o, mac_rm_o       MAC mode / rounding mode, constant per job
//   mac_out_i, mac_flags_i     MAC result and {NV,OF,UF,NX}
//   res_valid_o / res_ready_i  result handshake
//   res_data_o, res_flags_o    final accumulator and sticky flags
// -----------------------------------------------------------------------------
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int MAC_LAT = 2,
    parameter int KW      = 8,
    parameter int PARM_RM = 3
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [2:0]         job_mode_i,
    input  logic [PARM_RM-1:0] job_rm_i,
    input  logic [KW-1:0]      job_len_i,
    input  logic [ACC_W-1:0]   job_c_i,

    input  logic               op_valid_i,
    output logic               op_ready_o,
    input  logic [OP_W-1:0]    op_a_i,
    input  logic [OP_W-1:0]    op_b_i,

    output logic [OP_W-1:0]    mac_in1_o,
    output logic [OP_W-1:0]    mac_in2_o,
    output logic [ACC_W-1:0]   mac_in3_o,
    output logic [2:0]         mac_mode_o,
    output logic [PARM_RM-1:0] mac_rm_o,
    input  logic [ACC_W-1:0]   mac_out_i,
    input  logic [FLAG_W-1:0]  mac_flags_i,

    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [ACC_W-1:0]   res_data_o,
    output logic [FLAG_W-1:0]  res_flags_o
);

    // The latency counter runs 0..MAC_LAT, i.e. MAC_LAT+1 cycles per step.
    localparam int            LW       = $clog2(MAC_LAT + 2);
    localparam logic [LW-1:0] LAT_LAST = LW'(MAC_LAT);

    state_t              state;
    logic [KW-1:0]       remaining;
    logic [LW-1:0]       lat_cnt;
    logic [ACC_W-1:0]    acc;
    logic [FLAG_W-1:0]   flags;
    logic                fp_job;
    logic [FLAG_W-1:0]   flags_merged;
    logic                job_fire;
    logic                op_fire;
    logic                lat_done;

    // IN3 is the accumulator itself, so it is stable for the whole WAIT window.
    assign mac_in3_o = acc;

    assign job_fire = job_ready_o & job_valid_i;
    assign op_fire  = op_ready_o & op_valid_i;
    assign lat_done = (lat_cnt == LAT_LAST);

    // Integer and adjacent-add modes never contribute flags.
    assign flags_merged = flags | (fp_job ? mac_flags_i : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            lat_cnt     <= '0;
            acc         <= '0;
            flags       <= '0;
            fp_job      <= 1'b0;
            job_ready_o <= 1'b1;
            op_ready_o  <= 1'b0;
            res_valid_o <= 1'b0;
            mac_in1_o   <= '0;
            mac_in2_o   <= '0;
            mac_mode_o  <= MODE_FP32;
            mac_rm_o    <= '0;
            res_data_o  <= '0;
            res_flags_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (job_fire) begin
                        job_ready_o <= 1'b0;
                        flags       <= '0;
                        remaining   <= job_len_i;
                        lat_cnt     <= '0;
                        fp_job      <= is_fp_mode(job_mode_i);
                        if (job_mode_i == MODE_ILLEGAL) begin
                            // Nothing is issued; the illegal mode is never
                            // presented to the MAC.
                            acc         <= '0;
                            res_data_o  <= '0;
                            res_flags_o <= FLAGS_ILLEGAL;
                            res_valid_o <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            mac_mode_o <= job_mode_i;
                            mac_rm_o   <= job_rm_i;
                            acc        <= job_c_i;
                            if (job_mode_i == MODE_ADJ16) begin
                                // Single pass on IN3 alone; the length field
                                // is ignored and no operands are consumed.
                                mac_in1_o <= '0;
                                mac_in2_o <= '0;
                                remaining <= '0;
                                state     <= ST_WAIT;
                            end else if (job_len_i == '0) begin
                                res_data_o  <= job_c_i;
                                res_flags_o <= '0;
                                res_valid_o <= 1'b1;
                                state       <= ST_DONE;
                            end else begin
                                op_ready_o <= 1'b1;
                                state      <= ST_ISSUE;
                            end
                        end
                    end
                end

                ST_ISSUE: begin
                    if (op_fire) begin
                        mac_in1_o  <= op_a_i;
                        mac_in2_o  <= op_b_i;
                        remaining  <= remaining - 1'b1;
                        lat_cnt    <= '0;
                        op_ready_o <= 1'b0;
                        state      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (lat_done) begin
                        acc   <= mac_out_i;
                        flags <= flags_merged;
                        if (remaining != '0) begin
                            op_ready_o <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            res_data_o  <= mac_out_i;
                            res_flags_o <= flags_merged;
                            res_valid_o <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    // Result held until accepted; job_ready_o only returns
                    // in the following cycle.
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        job_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    job_ready_o <= 1'b1;
                    op_ready_o  <= 1'b0;
                    res_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;
    import mac_seq_pkg::*;

    localparam int MAC_LAT = 2;
    localparam int KW      = 8;
    localparam int PARM_RM = 3;

    logic               clk;
    logic               rst;
    logic               job_valid;
    logic               job_ready_o;
    logic [2:0]         job_mode;
    logic [PARM_RM-1:0] job_rm;
    logic [KW-1:0]      job_len;
    logic [127:0]       job_c;
    logic               op_valid;
    logic               op_ready_o;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [31:0]        mac_in1_o;
    logic [31:0]        mac_in2_o;
    logic [127:0]       mac_in3_o;
    logic [2:0]         mac_mode_o;
    logic [PARM_RM-1:0] mac_rm_o;
    logic [127:0]       mac_out;
    logic [3:0]         mac_flags;
    logic               res_valid_o;
    logic               res_ready;
    logic [127:0]       res_data_o;
    logic [3:0]         res_flags_o;

    mac_dot_sequencer #(.MAC_LAT(MAC_LAT), .KW(KW), .PARM_RM(PARM_RM)) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready_o),
        .job_mode_i  (job_mode),
        .job_rm_i    (job_rm),
        .job_len_i   (job_len),
        .job_c_i     (job_c),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready_o),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .mac_in1_o   (mac_in1_o),
        .mac_in2_o   (mac_in2_o),
        .mac_in3_o   (mac_in3_o),
        .mac_mode_o  (mac_mode_o),
        .mac_rm_o    (mac_rm_o),
        .mac_out_i   (mac_out),
        .mac_flags_i (mac_flags),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready),
        .res_data_o  (res_data_o),
        .res_flags_o (res_flags_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural MAC stand-in ----------------
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Returns {overflow, fp32 bits}; mantissa truncated, denormals flushed.
    function automatic logic [32:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 33'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, d[63], 31'd0};
        return {1'b0, d[63], e[7:0], d[51:29]};
    endfunction

    // Lane 0 carries the arithmetic. FP16 mode raises OF beyond the fp16
    // range. Integer modes drive a junk NX that the sequencer must ignore.
    function automatic logic [131:0] mac_model(input logic [2:0] m, input logic [31:0] a,
                                               input logic [31:0] b, input logic [127:0] c);
        logic [127:0] o;
        logic [3:0]   fl;
        real          r;
        logic [32:0]  q;
        o  = c;
        fl = 4'd0;
        case (m)
            3'b000, 3'b001, 3'b010: begin
                r = f2r(a) * f2r(b) + f2r(c[31:0]);
                q = r2f(r);
                o[31:0] = q[31:0];
                if (q[32] || (m == 3'b000 && (r >= 65536.0 || r <= -65536.0))) fl[2] = 1'b1;
            end
            3'b100: begin
                for (int j = 0; j < 4; j++)
                    o[32*j +: 32] = {16'd0, 16'(c[32*j +: 16] + c[32*j+16 +: 16])};
            end
            3'b011, 3'b101, 3'b110: begin
                o[31:0] = 32'(c[31:0] + 32'($signed(a) * $signed(b)));
                fl = 4'b0001;
            end
            default: o = '0;
        endcase
        return {fl, o};
    endfunction

    logic [131:0] pipe [MAC_LAT];
    always @(posedge clk) begin
        pipe[0] <= mac_model(mac_mode_o, mac_in1_o, mac_in2_o, mac_in3_o);
        for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mac_out   = pipe[MAC_LAT-1][127:0];
    assign mac_flags = pipe[MAC_LAT-1][131:128];

    // ---------------- bookkeeping ----------------
    int tests_run;
    int tests_failed;
    int cyc;
    int op_ready_cnt;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (op_ready_o) op_ready_cnt <= op_ready_cnt + 1;

    typedef struct {
        string              name;
        logic [2:0]         mode;
        logic [PARM_RM-1:0] rm;
        logic [127:0]       c;
        logic [KW-1:0]      len;
        logic [3:0][31:0]   a;
        logic [3:0][31:0]   b;
        logic [127:0]       exp_data;
        logic [3:0]         exp_flags;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [2:0] mode, input logic [PARM_RM-1:0] rm,
                                input logic [127:0] c, input logic [KW-1:0] len,
                                input logic [127:0] a, input logic [127:0] b,
                                input logic [127:0] exp_data, input logic [3:0] exp_flags);
        vec_t v;
        v.name = name; v.mode = mode; v.rm = rm; v.c = c; v.len = len;
        v.a = a; v.b = b; v.exp_data = exp_data; v.exp_flags = exp_flags;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: timed out waiting, expected handshake within bound", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] r_data;
    logic [3:0]   r_flags;
    int           acc_cyc;
    int           res_cyc;
    int           hs_cyc [4];
    bit           stall_ok;
    bit           hold_ok;

    task automatic run_job(input vec_t v, input int stall_idx, input int stall_len, input int hold_len);
        int          n;
        logic [31:0] s1;
        logic [31:0] s2;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        job_mode = v.mode; job_rm = v.rm; job_c = v.c; job_len = v.len; job_valid = 1'b1;
        n = 0;
        while (!job_ready_o) begin
            step(); n++;
            if (n > 50) begin timeout({v.name, " job"}); job_valid = 1'b0; return; end
        end
        step();
        job_valid = 1'b0;
        acc_cyc = cyc;
        if (v.mode != MODE_ILLEGAL && v.mode != MODE_ADJ16) begin
            for (int i = 0; i < int'(v.len); i++) begin
                if (i == stall_idx) begin
                    op_valid = 1'b0;
                    s1 = mac_in1_o;
                    s2 = mac_in2_o;
                    for (int s = 0; s < stall_len; s++) begin
                        step();
                        if (mac_in1_o !== s1 || mac_in2_o !== s2) stall_ok = 1'b0;
                    end
                end
                op_a = v.a[i]; op_b = v.b[i]; op_valid = 1'b1;
                n = 0;
                while (!op_ready_o) begin
                    step(); n++;
                    if (n > 50) begin timeout({v.name, " operand"}); op_valid = 1'b0; return; end
                end
                step();
                hs_cyc[i] = cyc;
            end
            op_valid = 1'b0;
        end
        n = 0;
        while (!res_valid_o) begin
            step(); n++;
            if (n > 50) begin timeout({v.name, " result"}); return; end
        end
        res_cyc = cyc;
        r_data  = res_data_o;
        r_flags = res_flags_o;
        for (int h = 0; h < hold_len; h++) begin
            step();
            if (res_valid_o !== 1'b1 || res_data_o !== r_data || res_flags_o !== r_flags || job_ready_o !== 1'b0)
                hold_ok = 1'b0;
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    vec_t         vt [9];
    logic [127:0] d_ref;
    logic [31:0]  in1_before;
    logic [31:0]  in2_before;
    int           cnt0;
    bit           quiet;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0; tests_failed = 0; op_ready_cnt = 0;
        rst = 1'b0; job_valid = 1'b0; job_mode = '0; job_rm = '0; job_len = '0; job_c = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;

        vt[0] = mk("fp32_k2", 3'b010, 3'd1, 128'h3F800000, 8'd2,
                   {32'd0, 32'd0, 32'h3F800000, 32'h40000000}, {32'd0, 32'd0, 32'h3F800000, 32'h40400000},
                   128'h41000000, 4'b0000);
        vt[1] = mk("k0_fp32", 3'b010, 3'd0, 128'h1234, 8'd0, '0, '0, 128'h1234, 4'b0000);
        vt[2] = mk("adj16", 3'b100, 3'd0, 128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'd5,
                   {4{32'h11111111}}, {4{32'h22222222}},
                   128'h00000003_00000007_0000000B_0000000F, 4'b0000);
        vt[3] = mk("int8mix_k3", 3'b110, 3'd0, 128'd10, 8'd3,
                   {32'd0, 32'hFFFFFFFF, 32'd4, 32'd2}, {32'd0, 32'd7, 32'd5, 32'd3},
                   128'h1D, 4'b0000);
        vt[4] = mk("fp16_of", 3'b000, 3'd2, 128'd0, 8'd2,
                   {32'd0, 32'd0, 32'hC7800000, 32'h47800000}, {32'd0, 32'd0, 32'h3F800000, 32'h3F800000},
                   128'd0, 4'b0100);
        vt[5] = mk("illegal", 3'b111, 3'd0, 128'hDEAD, 8'd3,
                   {4{32'h3F800000}}, {4{32'h3F800000}}, 128'd0, 4'b1000);
        vt[6] = mk("int4_k1", 3'b011, 3'd0, 128'h00000001_00000000_00000000_00000005, 8'd1,
                   {32'd0, 32'd0, 32'd0, 32'd100}, {32'd0, 32'd0, 32'd0, 32'hFFFFFFFE},
                   128'h00000001_00000000_00000000_FFFFFF3D, 4'b0000);
        vt[7] = mk("fp16mix_k1", 3'b001, 3'd3, 128'h40000000, 8'd1,
                   {32'd0, 32'd0, 32'd0, 32'h40400000}, {32'd0, 32'd0, 32'd0, 32'h40800000},
                   128'h41600000, 4'b0000);
        vt[8] = mk("k0_int4mix", 3'b101, 3'd0, 128'hFFFF0000_12345678_9ABCDEF0_0F0F0F0F, 8'd0, '0, '0,
                   128'hFFFF0000_12345678_9ABCDEF0_0F0F0F0F, 4'b0000);

        // Reset values, sampled while reset is held.
        step(); step();
        check("rst job_ready", 128'(job_ready_o), 128'd1);
        check("rst op_ready", 128'(op_ready_o), 128'd0);
        check("rst res_valid", 128'(res_valid_o), 128'd0);
        check("rst mac_in1", 128'(mac_in1_o), 128'd0);
        check("rst mac_in2", 128'(mac_in2_o), 128'd0);
        check("rst mac_in3", mac_in3_o, 128'd0);
        check("rst mac_mode", 128'(mac_mode_o), 128'd2);
        check("rst mac_rm", 128'(mac_rm_o), 128'd0);
        check("rst res_data", res_data_o, 128'd0);
        check("rst res_flags", 128'(res_flags_o), 128'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_job(vt[i], -1, 0, 0);
            check({vt[i].name, " data"}, r_data, vt[i].exp_data);
            check({vt[i].name, " flags"}, 128'(r_flags), 128'(vt[i].exp_flags));
        end

        // FP32 step period, result latency, job_ready after handshake, mode/rm latch.
        run_job(vt[0], -1, 0, 0);
        check("fp32 step period", 128'(hs_cyc[1] - hs_cyc[0]), 128'd4);
        check("fp32 result latency", 128'(res_cyc - hs_cyc[1]), 128'd3);
        check("fp32 job_ready after res", 128'(job_ready_o), 128'd1);
        check("fp32 mac_mode", 128'(mac_mode_o), 128'd2);
        check("fp32 mac_rm", 128'(mac_rm_o), 128'd1);

        // K=0: result in the cycle after accept, operand outputs untouched.
        in1_before = mac_in1_o;
        in2_before = mac_in2_o;
        run_job(vt[1], -1, 0, 0);
        check("k0 result latency", 128'(res_cyc - acc_cyc), 128'd0);
        check("k0 mac_in1 unchanged", 128'(mac_in1_o), 128'(in1_before));
        check("k0 mac_in2 unchanged", 128'(mac_in2_o), 128'(in2_before));

        // Illegal mode: result in the cycle after accept.
        run_job(vt[5], -1, 0, 0);
        check("illegal result latency", 128'(res_cyc - acc_cyc), 128'd0);

        // Adjacent add: never opens the operand port.
        cnt0 = op_ready_cnt;
        run_job(vt[2], -1, 0, 0);
        check("adj16 op_ready cycles", 128'(op_ready_cnt - cnt0), 128'd0);
        check("adj16 data again", r_data, vt[2].exp_data);

        // INT8 mix with a 5-cycle operand stall before the second pair.
        run_job(vt[3], -1, 0, 0);
        d_ref = r_data;
        run_job(vt[3], 1, 5, 0);
        check("int8 stall vs nostall", r_data, d_ref);
        check("int8 stall data", r_data, 128'h1D);
        check("int8 stall mac_in stable", 128'(stall_ok), 128'd1);

        // FP16 overflow on step 1 only, result held under 10 cycles of backpressure.
        run_job(vt[4], -1, 0, 10);
        check("fp16 hold stable", 128'(hold_ok), 128'd1);
        check("fp16 sticky OF", 128'(r_flags), 128'h4);
        check("fp16 data", r_data, 128'd0);

        // Reset pulsed during WAIT.
        job_mode = 3'b010; job_rm = 3'd1; job_c = 128'h3F800000; job_len = 8'd2; job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        op_a = 32'h40000000; op_b = 32'h40400000; op_valid = 1'b1;
        cnt0 = 0;
        while (!op_ready_o && cnt0 < 50) begin step(); cnt0++; end
        step();
        op_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("wait-rst op_ready", 128'(op_ready_o), 128'd0);
        check("wait-rst job_ready", 128'(job_ready_o), 128'd1);
        check("wait-rst res_valid", 128'(res_valid_o), 128'd0);
        check("wait-rst mac_in1", 128'(mac_in1_o), 128'd0);
        check("wait-rst mac_in3", mac_in3_o, 128'd0);
        check("wait-rst mac_mode", 128'(mac_mode_o), 128'd2);
        check("wait-rst mac_rm", 128'(mac_rm_o), 128'd0);
        step();
        step();
        rst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (res_valid_o !== 1'b0 || op_ready_o !== 1'b0 || job_ready_o !== 1'b1) quiet = 1'b0;
        end
        check("post-rst no result", 128'(quiet), 128'd1);
        run_job(vt[0], -1, 0, 0);
        check("post-rst fp32 data", r_data, 128'h41000000);
        check("post-rst fp32 flags", 128'(r_flags), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
